// File: rtl/motoro3_regs_ramp.sv
// motoro3 register block with soft-start/soft-stop ramping of reload and power.
// Optional build macro: M3REG_RAMP_EN. When it is defined, the outputs slew toward
// their targets on a prescaled tick. When it is undefined, the outputs jump to
// their targets one cycle after the FSM enters RAMP_UP or RAMP_DN.
module motoro3_regs_ramp #(
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned PWR_W      = 8,
  parameter int unsigned RELOAD_DEF = 1666667,
  parameter int unsigned RELOAD_MIN = 1667,
  parameter int unsigned PWR_DEF    = 16,
  parameter int unsigned RAMP_DIV   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [1:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic [CNT_W-1:0] m3reg_step_cnt_reload1,
  output logic [PWR_W-1:0] m3reg_power_percent,
  output logic             m3reg_run,
  output logic             m3reg_locked
);

  localparam logic [1:0] StStop   = 2'd0;
  localparam logic [1:0] StRampUp = 2'd1;
  localparam logic [1:0] StLock   = 2'd2;
  localparam logic [1:0] StRampDn = 2'd3;

  localparam logic [CNT_W-1:0] ReloadDef = CNT_W'(RELOAD_DEF);
  localparam logic [CNT_W-1:0] ReloadMin = CNT_W'(RELOAD_MIN);
  localparam logic [PWR_W-1:0] PwrDef    = PWR_W'(PWR_DEF);

  logic [CNT_W-1:0] rld_tgt_q, rld_tgt_d, step_q, step_d, rld_q, rld_d;
  logic [PWR_W-1:0] pwr_tgt_q, pwr_tgt_d, pwr_q, pwr_d;
  logic             run_q, run_d;
  logic [1:0]       state_q, state_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [CNT_W-1:0] wr_rld, wr_step, eff_rld, rld_next;
  logic [PWR_W-1:0] wr_pwr, eff_pwr, pwr_next;
  logic             tgt_change, upd;

  // Upper write-data bits are don't-care.
  logic unused_wr_hi;
  assign unused_wr_hi = ^wr_data[31:CNT_W];

  // Write decode: truncate, then clamp the reload floor and a zero step.
  always_comb begin
    wr_rld  = (wr_data[CNT_W-1:0] < ReloadMin) ? ReloadMin : wr_data[CNT_W-1:0];
    wr_pwr  = wr_data[PWR_W-1:0];
    wr_step = (wr_data[CNT_W-1:0] == '0) ? CNT_W'(1) : wr_data[CNT_W-1:0];
    rld_tgt_d = rld_tgt_q;
    pwr_tgt_d = pwr_tgt_q;
    step_d    = step_q;
    run_d     = run_q;
    if (wr_en) begin
      case (wr_addr)
        2'd0:    rld_tgt_d = wr_rld;
        2'd1:    pwr_tgt_d = wr_pwr;
        2'd2:    step_d    = wr_step;
        default: run_d     = wr_data[0];
      endcase
    end
    // Only a target write that would move an output leaves LOCK.
    tgt_change = wr_en && (((wr_addr == 2'd0) && (wr_rld != rld_q)) ||
                           ((wr_addr == 2'd1) && (wr_pwr != pwr_q)));
  end

  // Next FSM state; a run write is seen in the same cycle it is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStop: if (run_d) state_d = StRampUp;
      StRampUp: begin
        if (!run_d) state_d = StRampDn;
        else if ((rld_q == rld_tgt_d) && (pwr_q == pwr_tgt_d)) state_d = StLock;
      end
      StLock: begin
        if (!run_d) state_d = StRampDn;
        else if (tgt_change) state_d = StRampUp;
      end
      default: begin
        if (run_d) state_d = StRampUp;
        else if ((rld_q == ReloadDef) && (pwr_q == '0)) state_d = StStop;
      end
    endcase
  end

`ifdef M3REG_RAMP_EN
  localparam int unsigned      PrescW   = $clog2(RAMP_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(RAMP_DIV - 1);

  logic [PrescW-1:0] presc_q, presc_d;

  // Prescaler free-runs outside STOP and is pinned to 0 in STOP.
  always_comb begin
    if ((state_q == StStop) || (state_d == StStop)) presc_d = '0;
    else if (presc_q == PrescMax) presc_d = '0;
    else presc_d = presc_q + PrescW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign upd = (state_q != StStop) && (presc_q == PrescMax);
`else
  assign upd = (state_q == StRampUp) || (state_q == StRampDn);
`endif

  // Step the outputs toward the effective targets; old targets apply on a write+tick.
  always_comb begin
    eff_rld = (state_q == StRampDn) ? ReloadDef : rld_tgt_q;
    eff_pwr = (state_q == StRampDn) ? '0 : pwr_tgt_q;
`ifdef M3REG_RAMP_EN
    begin : ramp_step
      logic [CNT_W:0] rld_diff;
      if (rld_q > eff_rld) begin
        rld_diff = {1'b0, rld_q} - {1'b0, eff_rld};
        rld_next = (rld_diff > {1'b0, step_q}) ? (rld_q - step_q) : eff_rld;
      end else begin
        rld_diff = {1'b0, eff_rld} - {1'b0, rld_q};
        rld_next = (rld_diff > {1'b0, step_q}) ? (rld_q + step_q) : eff_rld;
      end
    end
    if (pwr_q < eff_pwr)      pwr_next = pwr_q + PWR_W'(1);
    else if (pwr_q > eff_pwr) pwr_next = pwr_q - PWR_W'(1);
    else                      pwr_next = pwr_q;
`else
    rld_next = eff_rld;
    pwr_next = eff_pwr;
`endif
    rld_d = rld_q;
    pwr_d = pwr_q;
    if (state_q == StStop) begin
      rld_d = ReloadDef;
      pwr_d = '0;
    end else if (upd) begin
      rld_d = rld_next;
      pwr_d = pwr_next;
    end
  end

  // Registered readback mux.
  always_comb begin
    case (rd_addr)
      2'd0:    rd_data_d = 32'(rld_tgt_q);
      2'd1:    rd_data_d = 32'(pwr_tgt_q);
      2'd2:    rd_data_d = 32'(step_q);
      default: rd_data_d = {28'd0, m3reg_locked, state_q, run_q};
    endcase
  end

  // Register file, FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rld_tgt_q <= ReloadDef;
      pwr_tgt_q <= PwrDef;
      step_q    <= CNT_W'(1);
      run_q     <= 1'b0;
      state_q   <= StStop;
      rld_q     <= ReloadDef;
      pwr_q     <= '0;
      rd_data_q <= '0;
    end else begin
      rld_tgt_q <= rld_tgt_d;
      pwr_tgt_q <= pwr_tgt_d;
      step_q    <= step_d;
      run_q     <= run_d;
      state_q   <= state_d;
      rld_q     <= rld_d;
      pwr_q     <= pwr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data                = rd_data_q;
  assign m3reg_step_cnt_reload1 = rld_q;
  assign m3reg_power_percent    = pwr_q;
  assign m3reg_run              = (state_q != StStop);
  assign m3reg_locked           = (state_q == StLock);

endmodule

// File: tb/tb_motoro3_regs_ramp.sv
// Directed bench for motoro3_regs_ramp; ramp scenarios run when M3REG_RAMP_EN is defined.
module tb_motoro3_regs_ramp;

  localparam int unsigned CNT_W = 25;
  localparam int unsigned PWR_W = 8;
  localparam logic [CNT_W-1:0] RDEF = 25'd1666667;

  logic             clk, rst, wr_en;
  logic [1:0]       wr_addr, rd_addr;
  logic [31:0]      wr_data, rd_data;
  logic [CNT_W-1:0] reload;
  logic [PWR_W-1:0] power;
  logic             run, locked;
  int               checks, errors;

  motoro3_regs_ramp #(
    .CNT_W(CNT_W), .PWR_W(PWR_W), .RELOAD_DEF(1666667), .RELOAD_MIN(1667),
    .PWR_DEF(16), .RAMP_DIV(10)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .m3reg_step_cnt_reload1(reload),
    .m3reg_power_percent(power), .m3reg_run(run), .m3reg_locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_addr = a;
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_addr = 2'd0;
    step(2);
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", rd_data); end
    rst = 1'b0;
    step(5000);
    checks++; if (reload !== RDEF) begin errors++; $display("FAIL rst_reload: got %0d want %0d", reload, RDEF); end
    checks++; if (power !== 8'd0) begin errors++; $display("FAIL rst_power: got %0d want 0", power); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_run: got %0b want 0", run); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b want 0", locked); end
    do_read(2'd1);
    checks++; if (rd_data !== 32'd16) begin errors++; $display("FAIL rst_pwr_tgt: got %0d want 16", rd_data); end
    do_read(2'd2);
    checks++; if (rd_data !== 32'd1) begin errors++; $display("FAIL rst_step: got %0d want 1", rd_data); end
    do_read(2'd3);
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %0d want 0", rd_data); end
  endtask

  task automatic test_writes();
    do_write(2'd0, 32'd5);
    do_read(2'd0);
    checks++; if (rd_data !== 32'd1667) begin errors++; $display("FAIL wr_min: got %0d want 1667", rd_data); end
    do_write(2'd2, 32'd0);
    do_read(2'd2);
    checks++; if (rd_data !== 32'd1) begin errors++; $display("FAIL wr_step0: got %0d want 1", rd_data); end
    do_write(2'd1, 32'h0000_01FF);
    do_read(2'd1);
    checks++; if (rd_data !== 32'd255) begin errors++; $display("FAIL wr_pwr_trunc: got %0d want 255", rd_data); end
    do_write(2'd0, 32'h8000_0000 + 32'd1400000);
    do_read(2'd0);
    checks++; if (rd_data !== 32'd1400000) begin errors++; $display("FAIL wr_rld_trunc: got %0d want 1400000", rd_data); end
    checks++; if (reload !== RDEF) begin errors++; $display("FAIL wr_stop_hold: got %0d want %0d", reload, RDEF); end
  endtask

`ifndef M3REG_RAMP_EN
  task automatic test_run_direct();
    do_write(2'd1, 32'd4);
    do_write(2'd3, 32'd1);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL dir_run: got %0b want 1", run); end
    checks++; if (power !== 8'd0) begin errors++; $display("FAIL dir_pwr0: got %0d want 0", power); end
    step(1);
    checks++; if (reload !== 25'd1400000) begin errors++; $display("FAIL dir_rld: got %0d want 1400000", reload); end
    checks++; if (power !== 8'd4) begin errors++; $display("FAIL dir_pwr: got %0d want 4", power); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL dir_lock_early: got %0b want 0", locked); end
    step(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL dir_lock: got %0b want 1", locked); end
    do_read(2'd3);
    checks++; if (rd_data !== 32'd13) begin errors++; $display("FAIL dir_ctrl: got %0d want 13", rd_data); end
  endtask

  task automatic test_lock_write();
    do_write(2'd1, 32'd4);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lk_same: got %0b want 1", locked); end
    do_write(2'd1, 32'd20);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lk_drop: got %0b want 0", locked); end
    step(1);
    checks++; if (power !== 8'd20) begin errors++; $display("FAIL lk_pwr: got %0d want 20", power); end
    step(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lk_relock: got %0b want 1", locked); end
  endtask

  task automatic test_stop_direct();
    do_write(2'd3, 32'd0);
    checks++; if (locked !== 1'b0 || run !== 1'b1) begin errors++; $display("FAIL dn_enter: got run %0b lock %0b want 1 0", run, locked); end
    do_read(2'd3);
    checks++; if (rd_data !== 32'd6) begin errors++; $display("FAIL dn_ctrl: got %0d want 6", rd_data); end
    checks++; if (reload !== RDEF || power !== 8'd0) begin errors++; $display("FAIL dn_load: got %0d/%0d want %0d/0", reload, power, RDEF); end
    step(1);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL dn_stop: got %0b want 0", run); end
  endtask

  task automatic test_reset_mid();
    do_write(2'd3, 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (reload !== RDEF || power !== 8'd0) begin errors++; $display("FAIL rm_out: got %0d/%0d want %0d/0", reload, power, RDEF); end
    checks++; if (run !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rm_state: got run %0b lock %0b want 0 0", run, locked); end
    do_read(2'd1);
    checks++; if (rd_data !== 32'd16) begin errors++; $display("FAIL rm_tgt: got %0d want 16", rd_data); end
  endtask
`else
  task automatic test_power_ramp();
    do_reset();
    do_write(2'd1, 32'd4);
    do_write(2'd3, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(9);
      checks++; if (power !== 8'(i - 1)) begin errors++; $display("FAIL pr_hold%0d: got %0d want %0d", i, power, i - 1); end
      step(1);
      checks++; if (power !== 8'(i)) begin errors++; $display("FAIL pr_step%0d: got %0d want %0d", i, power, i); end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL pr_lock_early: got %0b want 0", locked); end
    step(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pr_lock: got %0b want 1", locked); end
  endtask

  task automatic test_reload_ramp();
    logic [CNT_W-1:0] exp_rld [3];
    exp_rld[0] = 25'd1566667; exp_rld[1] = 25'd1466667; exp_rld[2] = 25'd1400000;
    do_reset();
    do_write(2'd2, 32'd100000);
    do_write(2'd0, 32'd1400000);
    do_write(2'd1, 32'd0);
    do_write(2'd3, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(9);
      checks++; if (reload !== ((i == 0) ? RDEF : exp_rld[i-1])) begin errors++; $display("FAIL rr_hold%0d: got %0d", i, reload); end
      step(1);
      checks++; if (reload !== exp_rld[i]) begin errors++; $display("FAIL rr_step%0d: got %0d want %0d", i, reload, exp_rld[i]); end
    end
    step(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rr_lock: got %0b want 1", locked); end
  endtask

  task automatic test_min_clamp();
    int n;
    do_write(2'd0, 32'd5);
    do_read(2'd0);
    checks++; if (rd_data !== 32'd1667) begin errors++; $display("FAIL mc_rd: got %0d want 1667", rd_data); end
    n = 0;
    while (locked !== 1'b1 && n < 400) begin step(1); n++; end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mc_timeout: locked %0b want 1", locked); end
    step(30);
    checks++; if (reload !== 25'd1667) begin errors++; $display("FAIL mc_floor: got %0d want 1667", reload); end
  endtask

  task automatic test_ramp_down();
    int n;
    do_reset();
    do_write(2'd3, 32'd1);
    n = 0;
    while (locked !== 1'b1 && n < 300) begin step(1); n++; end
    checks++; if (power !== 8'd16 || locked !== 1'b1) begin errors++; $display("FAIL rd_up: got %0d lock %0b want 16 1", power, locked); end
    do_write(2'd3, 32'd0);
    n = 0;
    while (power !== 8'd8 && n < 200) begin step(1); n++; end
    checks++; if (power !== 8'd8) begin errors++; $display("FAIL rd_mid: got %0d want 8", power); end
    do_write(2'd3, 32'd1);
    checks++; if (power !== 8'd8) begin errors++; $display("FAIL rd_nojump: got %0d want 8", power); end
    do_read(2'd3);
    checks++; if (rd_data !== 32'd3) begin errors++; $display("FAIL rd_ctrl_up: got %0d want 3", rd_data); end
    n = 0;
    while (locked !== 1'b1 && n < 300) begin step(1); n++; end
    checks++; if (power !== 8'd16) begin errors++; $display("FAIL rd_relock: got %0d want 16", power); end
    do_write(2'd3, 32'd0);
    n = 0;
    while (run !== 1'b0 && n < 400) begin step(1); n++; end
    checks++; if (run !== 1'b0 || power !== 8'd0 || reload !== RDEF) begin errors++; $display("FAIL rd_stop: got run %0b pwr %0d rld %0d", run, power, reload); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_write(2'd3, 32'd1);
    step(25);
    checks++; if (power !== 8'd2) begin errors++; $display("FAIL rm_pre: got %0d want 2", power); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (reload !== RDEF || power !== 8'd0) begin errors++; $display("FAIL rm_out: got %0d/%0d want %0d/0", reload, power, RDEF); end
    checks++; if (run !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rm_state: got run %0b lock %0b want 0 0", run, locked); end
    do_read(2'd3);
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rm_ctrl: got %0d want 0", rd_data); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_writes();
`ifndef M3REG_RAMP_EN
    test_run_direct();
    test_lock_write();
    test_stop_direct();
    test_reset_mid();
`else
    test_power_ramp();
    test_reload_ramp();
    test_min_clamp();
    test_ramp_down();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motoro3_regs_ramp.md
Name: motoro3_regs_ramp

Overview:
- Parametrised successor to the fixed motoro3 register block. Provides writable target speed (step-count reload) and power percent.
- Outputs slew toward their targets on a prescaled ramp tick, giving motor soft-start and soft-stop.
- Sits between the host write bus and the motoro3 step/PWM generators. Its outputs drive m3reg_step_cnt_reload1 and m3reg_power_percent directly.

Parameters:
- CNT_W, 25, width of step-count reload.
- PWR_W, 8, width of power percent.
- RELOAD_DEF, 1666667, reset/stopped reload value (1 Hz electrical at 10 MHz).
- RELOAD_MIN, 1667, floor for the reload target (1000 Hz max).
- PWR_DEF, 16, reset power target.
- RAMP_DIV, 1000, clocks per ramp tick (100 us at 10 MHz); must be ≥2.

Ports:
- clk  in  1  system clock, 10 MHz.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  write strobe, one cycle per write.
- wr_addr  in  2  register select: 0 = reload target, 1 = power target, 2 = reload step, 3 = control (bit0 run).
- wr_data  in  32  write data, LSB-aligned; upper bits ignored.
- rd_addr  in  2  readback select; same map, plus current values (see Behaviour).
- rd_data  out  32  readback, 1-cycle latency.
- m3reg_step_cnt_reload1  out  CNT_W  current ramped reload.
- m3reg_power_percent  out  PWR_W  current ramped power.
- m3reg_run  out  1  high in RAMP_UP, LOCK, RAMP_DN.
- m3reg_locked  out  1  high only in LOCK.

Behaviour:
- Single clock domain. Synchronous active-high reset. Every register updates on the clk rising edge only.
- Reset values:
  - reload target = RELOAD_DEF; power target = PWR_DEF; reload step = 1; run = 0.
  - Outputs: reload = RELOAD_DEF, power = 0, run = 0, locked = 0, rd_data = 0.
  - State = STOP; prescaler = 0.
- Writes:
  - A write takes effect the cycle after wr_en.
  - A reload target below RELOAD_MIN is stored as RELOAD_MIN.
  - A reload step of 0 is stored as 1.
  - Targets are truncated to CNT_W/PWR_W.
- Prescaler:
  - Counts 0..RAMP_DIV-1 and wraps. Tick is asserted for one cycle when the count equals RAMP_DIV-1.
  - Free-runs in every state except STOP, where it is held at 0.
- Per tick in RAMP_UP, LOCK, or RAMP_DN:
  - Reload moves toward its effective target by up to the reload step. It is clamped so it never overshoots.
  - Power moves toward its effective target by 1.
- Effective targets:
  - RAMP_UP and LOCK use the written targets.
  - RAMP_DN uses power target 0 and reload target RELOAD_DEF.
- Arithmetic: compute with a CNT_W+1 bit difference. No wrap is allowed at 0 or at max.
- FSM:
  - STOP: run=1 → RAMP_UP. Outputs held at reload=RELOAD_DEF, power=0.
  - RAMP_UP: both outputs equal targets after an update → LOCK. run=0 → RAMP_DN.
  - LOCK: a target write that differs from the output → RAMP_UP (locked drops the cycle after the write). run=0 → RAMP_DN.
  - RAMP_DN: power=0 and reload=RELOAD_DEF → STOP. run=1 → RAMP_UP; ramp continues from the current values with no jump.
- Simultaneous events:
  - A write that coincides with a tick is applied first. The tick uses the old target and the new target applies from the next tick.
  - A run write and a target write cannot collide (one address per cycle).
- Reset mid-ramp: immediately returns all outputs to reset values with no ramp. The power glitch to 0 is intentional (safe).
- Readback:
  - rd_addr 0–2 returns the targets/step.
  - rd_addr 3 returns {locked, state[1:0], run} in bits [3:0].
- Outputs are registered. The outputs change only on a tick, except on reset or entry to STOP.

Optional Feature:
- M3REG_RAMP_EN.
  - Defined: ramping as above.
  - Undefined: the prescaler is removed. In RAMP_UP, the outputs load their targets on the next cycle, then the FSM goes to LOCK. RAMP_DN loads power=0 and reload=RELOAD_DEF on the next cycle, then the FSM goes to STOP.
  - The FSM and port list are unchanged in both builds.

Test Plan:
- Reset, then idle 5000 clk → reload=1666667, power=0, run=0, locked=0. The prescaler stays 0.
- Write power target 4, run=1 (RAMP_DIV=10, reload target kept at default) → power steps 0,1,2,3,4 at 10-clk intervals; locked asserts after the 4th tick.
- Write reload step 100000, reload target 1400000, run=1 → reload steps 1566667, 1466667, then 1400000 (clamped, no overshoot), then LOCK.
- Write reload target 5 → readback addr 0 = 1667, and the output ramps down to 1667 and stops there.
- In LOCK at power 16, write run=0 → RAMP_DN, power decrements to 0 and reload returns to RELOAD_DEF, then STOP. Re-writing run=1 midway resumes RAMP_UP from the current value.
- Assert rst mid-RAMP_UP → the next cycle shows all outputs at reset values and state STOP.
- Build without M3REG_RAMP_EN, then write run=1 → outputs equal targets 1 cycle later and locked is high 2 cycles after the write.
